// File: rtl/ccsds123_pkg.sv
// Shared types and elaboration helpers for the CCSDS-123 output byte serializer.
package ccsds123_pkg;

    // Serializer word-holding state: nothing to send, or a word is being shifted out.
    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } ser_state_t;

    // Ceiling log2 for sizing pointers and counters at elaboration time.
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Number of bytes in one compressor output word.
    function automatic int bytes_per_word(input int bus_width);
        return bus_width / 8;
    endfunction

    // Width of the byte index that walks a word from MSB to LSB.
    function automatic int idx_width(input int bus_width);
        return log2_ceil(bus_width / 8);
    endfunction

endpackage

// File: rtl/ccsds123_sync_fifo.sv
// Single-clock word FIFO with a registered read port.
// rd_data updates only on a successful read, so it doubles as the holding
// register for the word currently being serialized downstream.
module ccsds123_sync_fifo
    import ccsds123_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [log2_ceil(DEPTH):0]   level
);

    localparam int ADDR_W = log2_ceil(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Pointers carry one extra bit so that full and empty are distinguishable.
    logic [ADDR_W:0]  wr_ptr_reg;
    logic [ADDR_W:0]  rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;
    logic             do_wr;
    logic             do_rd;

    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level == DEPTH_L);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign rd_data = rd_data_reg;

    // A write into a full FIFO is still legal when a read frees a slot on the same edge.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Storage array: written only, never reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Registered read port; cleared on reset so the output byte reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (do_rd) begin
            rd_data_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
        end
    end

    // Read and write pointers, wrapping naturally modulo twice the depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + (ADDR_W + 1)'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/ccsds123_byte_serializer.sv
// Buffers compressor output words (no backpressure upstream) and emits each
// word MSB-first as an 8-bit AXI4-Stream, flagging the last byte of an image.
module ccsds123_byte_serializer
    import ccsds123_pkg::*;
#(
    parameter int BUS_WIDTH  = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BUS_WIDTH-1:0]          in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic [7:0]                    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BYTES = bytes_per_word(BUS_WIDTH);
    localparam int IDX_W = idx_width(BUS_WIDTH);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BYTES - 1);

    ser_state_t       state_reg;
    ser_state_t       state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic             overflow_reg;

    logic             pop;
    logic             push;
    logic             loaded;
    logic             byte_accept;
    logic [BUS_WIDTH:0] word;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       byte_lane [BYTES];

    // The FIFO read register holds the word being serialized: {last, data}.
    ccsds123_sync_fifo #(
        .WIDTH (BUS_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({in_last, in_data}),
        .rd_en   (pop),
        .rd_data (word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Split the held word into byte lanes; lane 0 is the least significant byte.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        assign byte_lane[gi] = word[gi*8 +: 8];
    end

    assign loaded        = (state_reg == ST_LOADED);
    assign byte_accept   = loaded && m_axis_tready;
    assign m_axis_tvalid = loaded;
    assign m_axis_tdata  = byte_lane[idx_reg];
    assign m_axis_tlast  = loaded && (idx_reg == '0) && word[BUS_WIDTH];
    assign overflow      = overflow_reg;

    // A word is kept if there is room, or if this edge pops and frees a slot.
    assign push = in_valid && (!fifo_full || pop);

    // Next state, byte index and pop request for the word holding register.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    idx_next   = IDX_MAX;
                    state_next = ST_LOADED;
                end
            end
            ST_LOADED: begin
                if (byte_accept) begin
                    if (idx_reg != '0) begin
                        idx_next = idx_reg - IDX_W'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next word: no bubble between words.
                        pop      = 1'b1;
                        idx_next = IDX_MAX;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // State and byte index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            idx_reg   <= IDX_MAX;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Sticky overflow: set whenever an incoming word had to be dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (in_valid && !push) begin
            overflow_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ccsds123_byte_serializer.sv
// Self-checking bench for ccsds123_byte_serializer: a cycle table for the
// single-word case, then scoreboarded sequences for bursts, random tready,
// overflow, full-FIFO push/pop and mid-word reset.
module tb_ccsds123_byte_serializer;

    localparam int BW    = 64;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [7:0]    tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tlast;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    ccsds123_byte_serializer #(
        .BUS_WIDTH  (BW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    typedef struct {
        logic          in_valid;
        logic [BW-1:0] in_data;
        logic          in_last;
        logic          tready;
        logic          exp_tvalid;
        logic [7:0]    exp_tdata;
        logic          exp_tlast;
        logic [LW-1:0] exp_level;
    } vec_t;

    vec_t       vecs [11];
    logic [8:0] sb_q [$];
    int         errors = 0;
    int         checks = 0;
    bit         sb_en = 1'b0;
    bit         rand_mode = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    int         run_len;
    int         gap_cnt;
    int         tlast_cnt;
    int         last_pos;
    bit         run_ended;

    logic [BW-1:0] word_a;
    logic [BW-1:0] word_b;
    logic [BW-1:0] word_c;
    logic [BW-1:0] first_word;

    function automatic vec_t mk(input logic iv, input logic [BW-1:0] d, input logic il,
                                input logic rdy, input logic ev, input logic [7:0] ed,
                                input logic el, input logic [LW-1:0] lv);
        vec_t v;
        v.in_valid   = iv;
        v.in_data    = d;
        v.in_last    = il;
        v.tready     = rdy;
        v.exp_tvalid = ev;
        v.exp_tdata  = ed;
        v.exp_tlast  = el;
        v.exp_level  = lv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic chkl(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    // Scoreboard compare plus AXI hold-stability check, run mid-cycle.
    task automatic monitor();
        logic [8:0] e;
        if (rst || !sb_en) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            chk1("stall_tvalid", tvalid, 1'b1);
            chk8("stall_tdata", tdata, prev_data);
            chk1("stall_tlast", tlast, prev_last);
        end
        if (tvalid && tready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: actual=%02h required=no byte at %0t", tdata, $time);
            end else begin
                e = sb_q.pop_front();
                chk8("byte_data", tdata, e[7:0]);
                chk1("byte_last", tlast, e[8]);
            end
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            tready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic push_word(input logic [BW-1:0] d, input logic l, input bit kept);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        if (kept) begin
            for (int b = BW/8 - 1; b >= 0; b--) begin
                sb_q.push_back({(l && (b == 0)), d[b*8 +: 8]});
            end
        end
        $display("push word=%016h last=%0b expect_kept=%0b", d, l, kept);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        rand_mode = 1'b0;
        tready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        tick();
        chk(name, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic observe();
        if (tvalid) begin
            if (run_ended) gap_cnt++;
            run_len++;
            if (tlast) begin
                tlast_cnt++;
                last_pos = run_len;
            end
        end else if (run_len > 0) begin
            run_ended = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single word, tready high: per-cycle expected outputs.
        vecs[0] = mk(1'b1, 64'h0011223344556677, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, LW'(0));
        vecs[1] = mk(1'b0, '0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, LW'(1));
        for (int j = 0; j < 8; j++) begin
            vecs[2+j] = mk(1'b0, '0, 1'b0, 1'b1, 1'b1, 8'(j * 17), (j == 7), LW'(0));
        end
        vecs[10] = mk(1'b0, '0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, LW'(0));

        // Table: reset state, latency, MSB-first order, tlast on final byte.
        do_reset();
        sb_en = 1'b0;
        for (int k = 0; k < 11; k++) begin
            chk1($sformatf("tbl%0d_tvalid", k), tvalid, vecs[k].exp_tvalid);
            if (vecs[k].exp_tvalid || k == 0) begin
                chk8($sformatf("tbl%0d_tdata", k), tdata, vecs[k].exp_tdata);
            end
            chk1($sformatf("tbl%0d_tlast", k), tlast, vecs[k].exp_tlast);
            chkl($sformatf("tbl%0d_level", k), fifo_level, vecs[k].exp_level);
            chk1($sformatf("tbl%0d_overflow", k), overflow, 1'b0);
            in_valid = vecs[k].in_valid;
            in_data  = vecs[k].in_data;
            in_last  = vecs[k].in_last;
            tready   = vecs[k].tready;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Three back-to-back words: 24 contiguous bytes, tlast on the 24th.
        do_reset();
        sb_en     = 1'b1;
        tready    = 1'b1;
        run_len   = 0;
        gap_cnt   = 0;
        tlast_cnt = 0;
        last_pos  = 0;
        run_ended = 1'b0;
        for (int w = 0; w < 3; w++) begin
            push_word({$urandom(), $urandom()}, (w == 2), 1'b1);
            observe();
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            observe();
        end
        chk("burst_run_len", 64'(run_len), 64'd24);
        chk("burst_gaps", 64'(gap_cnt), 64'd0);
        chk("burst_tlast_count", 64'(tlast_cnt), 64'd1);
        chk("burst_tlast_pos", 64'(last_pos), 64'd24);
        chk("burst_drained", 64'(sb_q.size()), 64'd0);

        // Random tready over 100 words, images of 10 words each.
        do_reset();
        sb_en     = 1'b1;
        rand_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            push_word({$urandom(), $urandom()}, (i % 10 == 9), 1'b1);
            repeat ($urandom_range(12, 20)) tick();
        end
        drain("random_drained");
        chk1("random_overflow", overflow, 1'b0);
        rand_mode = 1'b0;

        // Stalled sink: 17 words fit (16 FIFO + shift reg), the 18th is dropped.
        do_reset();
        sb_en  = 1'b1;
        tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push_word({32'hA5A50000 + 32'(i), $urandom()}, 1'b0, 1'b1);
        end
        chk1("ovf17_overflow", overflow, 1'b0);
        chkl("ovf17_level", fifo_level, LW'(16));
        chk1("ovf17_tvalid", tvalid, 1'b1);
        push_word(64'hDEADBEEFDEADBEEF, 1'b1, 1'b0);
        chk1("ovf18_overflow", overflow, 1'b1);
        chkl("ovf18_level", fifo_level, LW'(16));
        repeat (3) tick();
        chk1("ovf_sticky", overflow, 1'b1);
        do_reset();
        chk1("ovf_cleared_by_reset", overflow, 1'b0);
        chkl("ovf_reset_level", fifo_level, LW'(0));

        // Full FIFO, push on the same edge as the last byte of the current word.
        sb_en      = 1'b1;
        tready     = 1'b0;
        first_word = {$urandom(), $urandom()};
        push_word(first_word, 1'b0, 1'b1);
        for (int i = 1; i < 17; i++) begin
            push_word({$urandom(), $urandom()}, (i == 16), 1'b1);
        end
        chkl("full_level_before", fifo_level, LW'(16));
        tready = 1'b1;
        repeat (7) tick();
        chk8("full_last_byte_of_word", tdata, first_word[7:0]);
        push_word({$urandom(), $urandom()}, 1'b1, 1'b1);
        chk1("full_pushpop_overflow", overflow, 1'b0);
        chkl("full_pushpop_level", fifo_level, LW'(16));
        drain("full_drained");
        chk1("full_end_overflow", overflow, 1'b0);

        // Reset while mid-word (idx=3), then a fresh word starts from its MSB.
        do_reset();
        sb_en  = 1'b1;
        tready = 1'b1;
        word_a = {$urandom(), $urandom()};
        word_b = {$urandom(), $urandom()};
        word_c = {$urandom(), $urandom()};
        push_word(word_a, 1'b0, 1'b1);
        push_word(word_b, 1'b1, 1'b1);
        repeat (4) tick();
        chk8("midword_idx3_byte", tdata, word_a[31:24]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        prev_stall = 1'b0;
        chk1("rst_tvalid", tvalid, 1'b0);
        chkl("rst_level", fifo_level, LW'(0));
        chk8("rst_tdata", tdata, 8'h00);
        chk1("rst_tlast", tlast, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        push_word(word_c, 1'b1, 1'b1);
        tick();
        chk1("after_rst_tvalid", tvalid, 1'b1);
        chk8("after_rst_msb", tdata, word_c[63:56]);
        drain("after_rst_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
